// File: rtl/mips_pkg.sv
// Shared pipeline encodings for the MIPS core: load opcodes, write-back source
// select and CP0 operation codes.
package mips_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;

    typedef enum logic [1:0] {
        MEMTOREG_RESULT = 2'b00,
        MEMTOREG_LOAD   = 2'b01,
        MEMTOREG_HL     = 2'b10,
        MEMTOREG_CP0    = 2'b11
    } memtoreg_e;

    localparam logic [2:0] CP0OP_MTC0 = 3'd1;

    // Byte lane within the word for a given byte address.
    function automatic logic [1:0] byte_lane(input logic [1:0] addr, input bit big_endian);
        return big_endian ? (2'd3 - addr) : addr;
    endfunction

    // Halfword lane within the word; addr[0] is ignored.
    function automatic logic half_lane(input logic [1:0] addr, input bit big_endian);
        return big_endian ? ~addr[1] : addr[1];
    endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// Load data extraction: picks the addressed byte/halfword out of the raw memory
// word and sign- or zero-extends it according to the load opcode.
module load_align
    import mips_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic [5:0]        op,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] dout,
    output logic [DATA_W-1:0] data
);

    logic [1:0]  lane;
    logic        hlane;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        lane   = byte_lane(addr, BIG_ENDIAN);
        hlane  = half_lane(addr, BIG_ENDIAN);
        byte_v = dout[{lane, 3'b000} +: 8];
        half_v = dout[{hlane, 4'b0000} +: 16];
        data   = dout;
        unique case (op)
            OP_LB:   data = {{(DATA_W-8){byte_v[7]}}, byte_v};
            OP_LBU:  data = {{(DATA_W-8){1'b0}}, byte_v};
            OP_LH:   data = {{(DATA_W-16){half_v[15]}}, half_v};
            OP_LHU:  data = {{(DATA_W-16){1'b0}}, half_v};
            default: data = dout;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: drives the GPR write port, owns the architectural HI/LO
// registers with a same-cycle bypass to EX, and issues mtc0 writes to CP0.
module wb_stage
    import mips_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     wr_dout,
    input  logic [DATA_W-1:0]     wr_result,
    input  logic [DATA_W-1:0]     wr_HL,
    input  logic [2*DATA_W-1:0]   wr_mult,
    input  logic [DATA_W-1:0]     wr_busA_mux2,
    input  logic [DATA_W-1:0]     wr_busB_mux2,
    input  logic [4:0]            wr_rw,
    input  logic                  wr_regWr,
    input  logic                  wr_multWr,
    input  logic                  wr_Highin,
    input  logic                  wr_Lowin,
    input  logic [1:0]            wr_memtoreg,
    input  logic [5:0]            wr_op,
    input  logic [2:0]            wr_cp0op,
    input  logic [4:0]            wr_cs,
    input  logic [2:0]            wr_sel,
    input  logic [DATA_W-1:0]     wr_cp0_dout,
    output logic                  rf_we,
    output logic [4:0]            rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic [DATA_W-1:0]     hi_q,
    output logic [DATA_W-1:0]     lo_q,
    output logic [DATA_W-1:0]     hi_fwd,
    output logic [DATA_W-1:0]     lo_fwd,
    output logic                  cp0_we,
    output logic [4:0]            cp0_addr,
    output logic [2:0]            cp0_sel,
    output logic [DATA_W-1:0]     cp0_wdata
);

    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] hi_d;
    logic [DATA_W-1:0] lo_d;

    load_align #(
        .DATA_W     (DATA_W),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_load_align (
        .op   (wr_op),
        .addr (wr_result[1:0]),
        .dout (wr_dout),
        .data (load_data)
    );

    always_comb begin
        rf_we    = wr_regWr & (wr_rw != 5'd0);
        rf_waddr = wr_rw;
        rf_wdata = wr_result;
        unique case (memtoreg_e'(wr_memtoreg))
            MEMTOREG_RESULT: rf_wdata = wr_result;
            MEMTOREG_LOAD:   rf_wdata = load_data;
            MEMTOREG_HL:     rf_wdata = wr_HL;
            MEMTOREG_CP0:    rf_wdata = wr_cp0_dout;
            default:         rf_wdata = wr_result;
        endcase
    end

    // A product write owns both halves; mthi/mtlo in the same cycle are lost.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (wr_multWr) begin
            {hi_d, lo_d} = wr_mult;
        end else begin
            if (wr_Highin) hi_d = wr_busA_mux2;
            if (wr_Lowin)  lo_d = wr_busA_mux2;
        end
        hi_fwd = hi_d;
        lo_fwd = lo_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    always_comb begin
        cp0_we    = (wr_cp0op == CP0OP_MTC0);
        cp0_addr  = wr_cs;
        cp0_sel   = wr_sel;
        cp0_wdata = wr_busB_mux2;
    end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed cases plus random MEM/WB words,
// expected outputs from a behavioural model of the write-back rules.
module tb_wb_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] wr_dout, wr_result, wr_HL, wr_busA_mux2, wr_busB_mux2, wr_cp0_dout;
    logic [63:0] wr_mult;
    logic [4:0]  wr_rw, wr_cs;
    logic        wr_regWr, wr_multWr, wr_Highin, wr_Lowin;
    logic [1:0]  wr_memtoreg;
    logic [5:0]  wr_op;
    logic [2:0]  wr_cp0op, wr_sel;
    logic        rf_we, cp0_we;
    logic [4:0]  rf_waddr, cp0_addr;
    logic [2:0]  cp0_sel;
    logic [31:0] rf_wdata, hi_q, lo_q, hi_fwd, lo_fwd, cp0_wdata;

    wb_stage #(.DATA_W(32), .BIG_ENDIAN(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_dout(wr_dout), .wr_result(wr_result), .wr_HL(wr_HL), .wr_mult(wr_mult),
        .wr_busA_mux2(wr_busA_mux2), .wr_busB_mux2(wr_busB_mux2), .wr_rw(wr_rw),
        .wr_regWr(wr_regWr), .wr_multWr(wr_multWr), .wr_Highin(wr_Highin), .wr_Lowin(wr_Lowin),
        .wr_memtoreg(wr_memtoreg), .wr_op(wr_op), .wr_cp0op(wr_cp0op), .wr_cs(wr_cs),
        .wr_sel(wr_sel), .wr_cp0_dout(wr_cp0_dout),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .hi_q(hi_q), .lo_q(lo_q), .hi_fwd(hi_fwd), .lo_fwd(lo_fwd),
        .cp0_we(cp0_we), .cp0_addr(cp0_addr), .cp0_sel(cp0_sel), .cp0_wdata(cp0_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dout, result, hl, busa, busb, cp0_dout;
        logic [63:0] mult;
        logic [4:0]  rw, cs;
        logic        regwr, multwr, highin, lowin;
        logic [1:0]  memtoreg;
        logic [5:0]  op;
        logic [2:0]  cp0op, sel;
    } stim_t;

    typedef struct {
        string       tag;
        logic        rf_we, cp0_we;
        logic [4:0]  rf_waddr, cp0_addr;
        logic [2:0]  cp0_sel;
        logic [31:0] rf_wdata, hi_fwd, lo_fwd, hi_q, lo_q, cp0_wdata;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    bit          done  = 1'b0;
    logic [31:0] hi_m  = 32'd0;
    logic [31:0] lo_m  = 32'd0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    // Load result from plain shift/mask arithmetic on the little-endian word.
    function automatic logic [31:0] model_load(input logic [5:0] op, input logic [1:0] addr,
                                               input logic [31:0] dout);
        logic [31:0] b, h;
        b = (dout >> (8 * int'(addr))) & 32'hFF;
        h = (dout >> (16 * int'(addr[1]))) & 32'hFFFF;
        case (op)
            6'h20:   return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            6'h24:   return b;
            6'h21:   return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            6'h25:   return h;
            default: return dout;
        endcase
    endfunction

    task automatic apply(input string tag, input stim_t s);
        exp_t        e;
        logic [31:0] nhi, nlo;
        @(posedge clk);
        #1;
        wr_dout = s.dout; wr_result = s.result; wr_HL = s.hl; wr_mult = s.mult;
        wr_busA_mux2 = s.busa; wr_busB_mux2 = s.busb; wr_cp0_dout = s.cp0_dout;
        wr_rw = s.rw; wr_regWr = s.regwr; wr_multWr = s.multwr; wr_Highin = s.highin;
        wr_Lowin = s.lowin; wr_memtoreg = s.memtoreg; wr_op = s.op; wr_cp0op = s.cp0op;
        wr_cs = s.cs; wr_sel = s.sel;

        e.tag      = tag;
        e.rf_we    = s.regwr && (s.rw != 5'd0);
        e.rf_waddr = s.rw;
        case (s.memtoreg)
            2'd0:    e.rf_wdata = s.result;
            2'd1:    e.rf_wdata = model_load(s.op, s.result[1:0], s.dout);
            2'd2:    e.rf_wdata = s.hl;
            default: e.rf_wdata = s.cp0_dout;
        endcase
        nhi = hi_m;
        nlo = lo_m;
        if (s.multwr) begin
            nhi = s.mult[63:32];
            nlo = s.mult[31:0];
        end else begin
            if (s.highin) nhi = s.busa;
            if (s.lowin)  nlo = s.busa;
        end
        e.hi_q      = hi_m;
        e.lo_q      = lo_m;
        e.hi_fwd    = nhi;
        e.lo_fwd    = nlo;
        e.cp0_we    = (s.cp0op == 3'd1);
        e.cp0_addr  = s.cs;
        e.cp0_sel   = s.sel;
        e.cp0_wdata = s.busb;
        sb.push_back(e);
        hi_m = nhi;
        lo_m = nlo;
    endtask

    initial begin : monitor
        exp_t e;
        while (!done) begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.tag, ".rf_we"},     64'(rf_we),     64'(e.rf_we));
                chk({e.tag, ".rf_waddr"},  64'(rf_waddr),  64'(e.rf_waddr));
                chk({e.tag, ".rf_wdata"},  64'(rf_wdata),  64'(e.rf_wdata));
                chk({e.tag, ".hi_fwd"},    64'(hi_fwd),    64'(e.hi_fwd));
                chk({e.tag, ".lo_fwd"},    64'(lo_fwd),    64'(e.lo_fwd));
                chk({e.tag, ".hi_q"},      64'(hi_q),      64'(e.hi_q));
                chk({e.tag, ".lo_q"},      64'(lo_q),      64'(e.lo_q));
                chk({e.tag, ".cp0_we"},    64'(cp0_we),    64'(e.cp0_we));
                chk({e.tag, ".cp0_addr"},  64'(cp0_addr),  64'(e.cp0_addr));
                chk({e.tag, ".cp0_sel"},   64'(cp0_sel),   64'(e.cp0_sel));
                chk({e.tag, ".cp0_wdata"}, 64'(cp0_wdata), 64'(e.cp0_wdata));
            end
        end
    end

    task automatic zero_inputs();
        wr_dout = '0; wr_result = '0; wr_HL = '0; wr_mult = '0; wr_busA_mux2 = '0;
        wr_busB_mux2 = '0; wr_cp0_dout = '0; wr_rw = '0; wr_regWr = 1'b0; wr_multWr = 1'b0;
        wr_Highin = 1'b0; wr_Lowin = 1'b0; wr_memtoreg = '0; wr_op = '0; wr_cp0op = '0;
        wr_cs = '0; wr_sel = '0;
    endtask

    initial begin : driver
        stim_t s;
        logic [5:0] ops [6];
        int drain;
        ops[0] = 6'h20; ops[1] = 6'h21; ops[2] = 6'h23;
        ops[3] = 6'h24; ops[4] = 6'h25; ops[5] = 6'h0F;

        rst_n = 1'b0;
        zero_inputs();
        #3;
        chk("reset.hi_q",   64'(hi_q),   64'd0);
        chk("reset.lo_q",   64'(lo_q),   64'd0);
        chk("reset.rf_we",  64'(rf_we),  64'd0);
        chk("reset.cp0_we", 64'(cp0_we), 64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        s = '{default: '0};
        s.dout = 32'h8899AABB; s.result = 32'h0000_1001; s.memtoreg = 2'b01;
        s.regwr = 1'b1; s.rw = 5'd3; s.op = 6'h20;
        apply("lb", s);
        s.op = 6'h24;
        apply("lbu", s);
        s.op = 6'h21; s.result = 32'h0000_1002;
        apply("lh", s);
        s.op = 6'h25; s.result = 32'h0000_1003;
        apply("lhu_misaligned", s);
        s.op = 6'h23; s.result = 32'h0000_1001;
        apply("lw_misaligned", s);

        s = '{default: '0};
        s.regwr = 1'b1; s.rw = 5'd0; s.result = 32'd5;
        apply("r0", s);

        s = '{default: '0};
        s.multwr = 1'b1; s.mult = 64'h1_0000_0002;
        apply("mult", s);
        s = '{default: '0};
        s.memtoreg = 2'b10; s.hl = 32'h1; s.regwr = 1'b1; s.rw = 5'd9;
        apply("mfhi", s);

        s = '{default: '0};
        s.multwr = 1'b1; s.highin = 1'b1; s.lowin = 1'b1; s.busa = 32'hDEAD;
        s.mult = 64'h1234_5678_9ABC_DEF0;
        apply("collision", s);
        s = '{default: '0};
        s.highin = 1'b1; s.lowin = 1'b1; s.busa = 32'hCAFE_0001;
        apply("mthi_mtlo", s);

        s = '{default: '0};
        s.cp0op = 3'd1; s.cs = 5'd12; s.sel = 3'd0; s.busb = 32'h0000FF01;
        s.memtoreg = 2'b11; s.cp0_dout = 32'h4000_0000; s.rw = 5'd7; s.regwr = 1'b1;
        apply("mtc0", s);

        s = '{default: '0};
        apply("bubble", s);

        // Asynchronous reset between edges with HI/LO live and a mult pending.
        s = '{default: '0};
        s.multwr = 1'b1; s.mult = 64'h0000_0007_0000_0009;
        apply("pre_reset", s);
        @(posedge clk);
        #1;
        zero_inputs();
        wr_multWr = 1'b1;
        wr_mult = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        chk("pre_reset.hi_q", 64'(hi_q), 64'(hi_m));
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset.hi_q", 64'(hi_q), 64'd0);
        chk("async_reset.lo_q", 64'(lo_q), 64'd0);
        hi_m = 32'd0;
        lo_m = 32'd0;
        @(negedge clk);
        #1;
        zero_inputs();
        rst_n = 1'b1;

        for (int i = 0; i < 300; i++) begin
            s = '{default: '0};
            if ($urandom_range(0, 15) != 0) begin
                s.dout     = $urandom;
                s.result   = $urandom;
                s.hl       = $urandom;
                s.busa     = $urandom;
                s.busb     = $urandom;
                s.cp0_dout = $urandom;
                s.mult     = {$urandom, $urandom};
                s.rw       = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
                s.regwr    = 1'($urandom);
                s.multwr   = ($urandom_range(0, 3) == 0);
                s.highin   = 1'($urandom);
                s.lowin    = 1'($urandom);
                s.memtoreg = 2'($urandom);
                s.op       = ops[$urandom_range(0, 5)];
                s.cp0op    = ($urandom_range(0, 1) == 0) ? 3'd1 : 3'($urandom);
                s.cs       = 5'($urandom);
                s.sel      = 3'($urandom);
            end
            apply("rand", s);
        end

        drain = 0;
        while (sb.size() > 0 && drain < 20) begin
            @(posedge clk);
            drain++;
        end
        if (sb.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        @(posedge clk);
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
